ov7670_mem_writer: RTL

OV7670_MEM_WRITER -- requirements
Module: ov7670_mem_writer

---
 rtl/ov7670_mem_writer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ov7670_mem_writer.sv
// ov7670_mem_writer
//   Captures RGB565 frames from an OV7670-style camera byte stream and turns
//   them into single-cycle frame-buffer writes. Each pixel arrives as two
//   bytes (high byte first) while HREF is high; VSYNC high marks vertical
//   blanking. Frames are only captured when capture_en is high at frame start.
//
// Ports
//   pclk        camera pixel clock, sole clock, rising edge
//   reset_n     synchronous active-low reset
//   capture_en  capture enable, sampled at frame start only
//   vsync       camera VSYNC (1 = vertical blanking)
//   href        camera HREF  (1 = active line byte on data)
//   data        camera byte bus
//   we          frame-buffer write strobe, one pclk per pixel
//   wAddr       frame-buffer write address, y*H_PIX+x
//   wData       RGB565 pixel {first byte, second byte}
//   frame_done  1-cycle pulse at end of a captured frame
//   frame_err   sticky error for the current frame, cleared at frame start
module ov7670_mem_writer #(
    parameter int  H_PIX = 320,
    parameter int  V_PIX = 240,
    localparam int AW    = $clog2(H_PIX * V_PIX)
) (
    input  logic          pclk,
    input  logic          reset_n,
    input  logic          capture_en,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    data,
    output logic          we,
    output logic [AW-1:0] wAddr,
    output logic [15:0]   wData,
    output logic          frame_done,
    output logic          frame_err
);

    localparam int NPIX = H_PIX * V_PIX;
    localparam int XW   = $clog2(H_PIX + 1);
    localparam int YW   = $clog2(V_PIX + 1);
    localparam int CW   = $clog2(NPIX + 1);

    localparam logic [XW-1:0] X_END  = XW'(H_PIX);
    localparam logic [YW-1:0] Y_END  = YW'(V_PIX);
    localparam logic [YW-1:0] Y_LAST = YW'(V_PIX - 1);
    localparam logic [AW-1:0] A_LAST = AW'(NPIX - 1);
    localparam logic [AW-1:0] A_STEP = AW'(H_PIX);
    localparam logic [CW-1:0] C_FULL = CW'(NPIX);

    typedef enum logic [1:0] {
        SYNC,
        WAIT_START,
        CAPTURE
    } state_t;

    state_t        state_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          phase_q;       // 0: expecting high byte, 1: expecting low byte
    logic [7:0]    hi_q;
    logic          href_q;        // previous href, for line-end detection
    logic [AW-1:0] addr_q;        // address of the next committed write
    logic [AW-1:0] line_base_q;   // y*H_PIX kept as a running sum
    logic [CW-1:0] wr_cnt_q;      // pixels written this frame
    logic          we_q;
    logic [AW-1:0] wAddr_q;
    logic [15:0]   wData_q;
    logic          frame_done_q;
    logic          frame_err_q;

    logic [AW-1:0] line_base_d;
    logic          pix_in_range;
    logic          line_end;

    // Next line start. Only taken while another in-range line follows, so the
    // address never points past the last pixel.
    assign line_base_d  = line_base_q + A_STEP;
    assign pix_in_range = (x_q < X_END) && (y_q < Y_END);
    assign line_end     = href_q && !href;

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            state_q      <= SYNC;
            x_q          <= '0;
            y_q          <= '0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            href_q       <= 1'b0;
            addr_q       <= '0;
            line_base_q  <= '0;
            wr_cnt_q     <= '0;
            we_q         <= 1'b0;
            wAddr_q      <= '0;
            wData_q      <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            we_q         <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                // Stream content is meaningless until blanking has been seen.
                SYNC: begin
                    if (vsync) state_q <= WAIT_START;
                end

                WAIT_START: begin
                    if (!vsync) begin
                        x_q         <= '0;
                        y_q         <= '0;
                        phase_q     <= 1'b0;
                        href_q      <= 1'b0;
                        addr_q      <= '0;
                        line_base_q <= '0;
                        wr_cnt_q    <= '0;
                        frame_err_q <= 1'b0;
                        state_q     <= capture_en ? CAPTURE : SYNC;
                    end
                end

                CAPTURE: begin
                    href_q <= href;
                    if (vsync) begin
                        // Frame end wins over any byte presented this cycle.
                        frame_done_q <= 1'b1;
                        if (wr_cnt_q != C_FULL) frame_err_q <= 1'b1;
                        state_q <= WAIT_START;
                    end else if (href) begin
                        phase_q <= ~phase_q;
                        if (!phase_q) begin
                            hi_q <= data;
                        end else if (pix_in_range) begin
                            we_q     <= 1'b1;
                            wData_q  <= {hi_q, data};
                            wAddr_q  <= addr_q;
                            if (addr_q != A_LAST) addr_q <= addr_q + AW'(1);
                            x_q      <= x_q + XW'(1);
                            wr_cnt_q <= wr_cnt_q + CW'(1);
                        end else begin
                            // Overrun: pixel dropped, x stays saturated.
                            frame_err_q <= 1'b1;
                        end
                    end else if (line_end) begin
                        // Odd byte count or wrong pixel count flags the frame;
                        // a pending high byte is simply abandoned.
                        if (phase_q || (x_q != X_END)) frame_err_q <= 1'b1;
                        x_q     <= '0;
                        phase_q <= 1'b0;
                        if (y_q != Y_END) y_q <= y_q + YW'(1);
                        // Realign to the next line start so a short line does
                        // not shift every following line.
                        if (y_q < Y_LAST) begin
                            line_base_q <= line_base_d;
                            addr_q      <= line_base_d;
                        end
                    end
                end

                default: state_q <= SYNC;
            endcase
        end
    end

    assign we         = we_q;
    assign wAddr      = wAddr_q;
    assign wData      = wData_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule
